// File: rtl/sdr_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdr_pipe_arbiter
// Description : Two-requester front end for a shared fixed-latency,
//               non-stallable sample pipeline. A tag shift register runs
//               alongside the pipeline so each result returns to its owner.
//               Define SDR_PIPE_ARB_PRIO_EN for strict A-over-B priority;
//               the default is round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module sdr_pipe_arbiter #(
    parameter int DATA_W  = 48,
    parameter int LATENCY = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              a_valid_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,
    input  logic              b_valid_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,
    input  logic              flush_i,
    output logic [DATA_W-1:0] pipe_data_o,
    input  logic [DATA_W-1:0] pipe_data_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic              a_valid_o,
    output logic              b_valid_o,
    output logic              busy_o
);

    localparam logic c_ID_A = 1'b0;
    localparam logic c_ID_B = 1'b1;

    logic                r_last_grant;
    logic [LATENCY:0]    r_tag_vld;
    logic [LATENCY:0]    r_tag_id;
    logic [DATA_W-1:0]   r_pipe_data;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_a_valid;
    logic                r_b_valid;

    logic                w_gate;
    logic                w_a_ready;
    logic                w_b_ready;
    logic                w_issue;
    logic                w_issue_id;
    logic [DATA_W-1:0]   w_issue_data;

    assign w_gate = !flush_i && !rst_i;

    always_comb begin
        w_a_ready = 1'b0;
        w_b_ready = 1'b0;
`ifdef SDR_PIPE_ARB_PRIO_EN
        w_a_ready = w_gate && a_valid_i;
        w_b_ready = w_gate && b_valid_i && !a_valid_i;
`else
        w_a_ready = w_gate && a_valid_i && (!b_valid_i || (r_last_grant == c_ID_B));
        w_b_ready = w_gate && b_valid_i && (!a_valid_i || (r_last_grant == c_ID_A));
`endif
    end

    assign w_issue      = w_a_ready || w_b_ready;
    assign w_issue_id   = w_b_ready ? c_ID_B : c_ID_A;
    assign w_issue_data = w_b_ready ? b_data_i : (w_a_ready ? a_data_i : '0);

    // Tag stage 0 is paired with the pipe_data_o register; stage LATENCY
    // lines up with the sample arriving on pipe_data_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= c_ID_B;
            r_tag_vld    <= '0;
            r_tag_id     <= '0;
            r_pipe_data  <= '0;
            r_res_data   <= '0;
            r_a_valid    <= 1'b0;
            r_b_valid    <= 1'b0;
        end else if (flush_i) begin
            r_tag_vld    <= '0;
            r_pipe_data  <= '0;
            r_a_valid    <= 1'b0;
            r_b_valid    <= 1'b0;
        end else begin
            r_pipe_data <= w_issue_data;
            r_tag_vld   <= {r_tag_vld[LATENCY-1:0], w_issue};
            r_tag_id    <= {r_tag_id[LATENCY-1:0], w_issue_id};
            if (w_issue) begin
                r_last_grant <= w_issue_id;
            end
            if (r_tag_vld[LATENCY]) begin
                r_res_data <= pipe_data_i;
            end
            r_a_valid <= r_tag_vld[LATENCY] && (r_tag_id[LATENCY] == c_ID_A);
            r_b_valid <= r_tag_vld[LATENCY] && (r_tag_id[LATENCY] == c_ID_B);
        end
    end

    assign a_ready_o   = w_a_ready;
    assign b_ready_o   = w_b_ready;
    assign pipe_data_o = r_pipe_data;
    assign res_data_o  = r_res_data;
    assign a_valid_o   = r_a_valid;
    assign b_valid_o   = r_b_valid;
    assign busy_o      = (|r_tag_vld) || r_a_valid || r_b_valid;

endmodule
`default_nettype wire

// File: tb/tb_sdr_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdr_pipe_arbiter
// Description : Scoreboard bench for sdr_pipe_arbiter with a register-chain
//               datapath of LATENCY stages.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdr_pipe_arbiter;

    localparam int DATA_W  = 48;
    localparam int LATENCY = 15;
    localparam int c_RES_LAT = LATENCY + 2;

    logic              clk;
    logic              rst_i;
    logic              a_valid_i, b_valid_i, flush_i;
    logic [DATA_W-1:0] a_data_i, b_data_i;
    logic              a_ready_o, b_ready_o;
    logic [DATA_W-1:0] pipe_data_o, pipe_data_i, res_data_o;
    logic              a_valid_o, b_valid_o, busy_o;

    sdr_pipe_arbiter #(.DATA_W(DATA_W), .LATENCY(LATENCY)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .a_valid_i   (a_valid_i),
        .a_data_i    (a_data_i),
        .a_ready_o   (a_ready_o),
        .b_valid_i   (b_valid_i),
        .b_data_i    (b_data_i),
        .b_ready_o   (b_ready_o),
        .flush_i     (flush_i),
        .pipe_data_o (pipe_data_o),
        .pipe_data_i (pipe_data_i),
        .res_data_o  (res_data_o),
        .a_valid_o   (a_valid_o),
        .b_valid_o   (b_valid_o),
        .busy_o      (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached datapath: plain register chain
    logic [DATA_W-1:0] r_dp [LATENCY];
    always @(posedge clk) begin
        r_dp[0] <= pipe_data_o;
        for (int i = 1; i < LATENCY; i++) r_dp[i] <= r_dp[i-1];
    end
    assign pipe_data_i = r_dp[LATENCY-1];

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic              id;
        logic [DATA_W-1:0] data;
        int unsigned       cyc;
    } exp_t;
    exp_t q[$];

    int  n_chk  = 0;
    int  n_fail = 0;
    bit  mon_en = 1'b0;
    logic lg_model = 1'b1;  // 0 = A, 1 = B

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Result monitor: pops the scoreboard whenever a result valid appears
    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check_eq("busy", {63'd0, busy_o}, {63'd0, q.size() != 0});
            if (a_valid_o || b_valid_o) begin
                check_eq("valid_onehot", {63'd0, a_valid_o & b_valid_o}, 64'd0);
                if (q.size() == 0) begin
                    check_eq("unexpected_valid", {62'd0, a_valid_o, b_valid_o}, 64'd0);
                end else begin
                    e = q.pop_front();
                    check_eq("res_owner", {63'd0, b_valid_o}, {63'd0, e.id});
                    check_eq("res_data", {16'd0, res_data_o}, {16'd0, e.data});
                    check_eq("res_latency", 64'(cyc - e.cyc), 64'(c_RES_LAT));
                end
            end
        end
    end

    // One clock of stimulus; returns which requesters were accepted.
    task automatic drive(input logic av, input logic [DATA_W-1:0] ad,
                         input logic bv, input logic [DATA_W-1:0] bd,
                         input logic fl, input logic rs,
                         output logic acc_a, output logic acc_b);
        logic ea, eb;
        exp_t e;
        @(negedge clk);
        a_valid_i = av; a_data_i = ad;
        b_valid_i = bv; b_data_i = bd;
        flush_i = fl;   rst_i = rs;
        #1;
`ifdef SDR_PIPE_ARB_PRIO_EN
        ea = !fl && !rs && av;
        eb = !fl && !rs && bv && !av;
`else
        ea = !fl && !rs && av && (!bv || lg_model == 1'b1);
        eb = !fl && !rs && bv && (!av || lg_model == 1'b0);
`endif
        check_eq("a_ready", {63'd0, a_ready_o}, {63'd0, ea});
        check_eq("b_ready", {63'd0, b_ready_o}, {63'd0, eb});
        acc_a = ea;
        acc_b = eb;
        if (fl || rs) q.delete();
        if (rs) lg_model = 1'b1;
        if (ea) begin
            e.id = 1'b0; e.data = ad; e.cyc = cyc; q.push_back(e); lg_model = 1'b0;
        end
        if (eb) begin
            e.id = 1'b1; e.data = bd; e.cyc = cyc; q.push_back(e); lg_model = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        logic xa, xb;
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, xa, xb);
    endtask

    task automatic do_reset(input int n);
        logic xa, xb;
        for (int i = 0; i < n; i++) drive(1'b1, 48'hDEAD, 1'b1, 48'hBEEF, 1'b0, 1'b1, xa, xb);
    endtask

    task automatic drain();
        int k = 0;
        while (q.size() != 0 && k < 4 * c_RES_LAT) begin
            idle(1);
            k++;
        end
        check_eq("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic check_reset_outputs();
        @(negedge clk);
        #2;
        check_eq("rst_pipe_data", {16'd0, pipe_data_o}, 64'd0);
        check_eq("rst_res_data",  {16'd0, res_data_o}, 64'd0);
        check_eq("rst_a_valid",   {63'd0, a_valid_o}, 64'd0);
        check_eq("rst_b_valid",   {63'd0, b_valid_o}, 64'd0);
        check_eq("rst_busy",      {63'd0, busy_o}, 64'd0);
    endtask

    initial begin
        logic xa, xb;
        int   na, nb;
        a_valid_i = 0; b_valid_i = 0; flush_i = 0; rst_i = 1;
        a_data_i = '0; b_data_i = '0;

        // Reset and idle state
        do_reset(3);
        mon_en = 1'b1;
        check_reset_outputs();

        // A alone, data 1..20
        for (int n = 1; n <= 20; n++) drive(1'b1, DATA_W'(n), 1'b0, '0, 1'b0, 1'b0, xa, xb);
        drain();

        // Both continuously valid: strict alternation starting with A
        do_reset(1);
        na = 0; nb = 0;
        for (int n = 0; n < 16; n++) begin
            drive(1'b1, DATA_W'(8'hA0 + na), 1'b1, DATA_W'(8'hB0 + nb), 1'b0, 1'b0, xa, xb);
            check_eq("alt_grant_a", {63'd0, xa}, {63'd0, (n % 2) == 0});
            if (xa) na++;
            if (xb) nb++;
        end
        drain();

        // Flush with samples in flight and a held request
        for (int n = 0; n < 5; n++) drive(1'b1, DATA_W'(16'h100 + n), 1'b0, '0, 1'b0, 1'b0, xa, xb);
        idle(2);
        drive(1'b1, DATA_W'(16'h155), 1'b0, '0, 1'b1, 1'b0, xa, xb);
        check_eq("flush_no_accept", {63'd0, xa}, 64'd0);
        drive(1'b1, DATA_W'(16'h155), 1'b0, '0, 1'b0, 1'b0, xa, xb);
        check_eq("post_flush_accept", {63'd0, xa}, 64'd1);
        drain();

        // Reset mid-stream
        for (int n = 0; n < 6; n++) drive(1'b1, DATA_W'(16'h200 + n), 1'b1, DATA_W'(16'h300 + n), 1'b0, 1'b0, xa, xb);
        drive(1'b0, '0, 1'b1, DATA_W'(16'h3FF), 1'b0, 1'b0, xa, xb);
        do_reset(1);
        check_reset_outputs();
        drive(1'b1, DATA_W'(16'h2A0), 1'b1, DATA_W'(16'h3A0), 1'b0, 1'b0, xa, xb);
        check_eq("post_rst_first_a", {63'd0, xa}, 64'd1);
        drain();

        // Both valid 10 cycles, then A drops
        na = 0; nb = 0;
        for (int n = 0; n < 10; n++) begin
            drive(1'b1, DATA_W'(16'h400 + na), 1'b1, DATA_W'(16'h500 + nb), 1'b0, 1'b0, xa, xb);
`ifdef SDR_PIPE_ARB_PRIO_EN
            check_eq("prio_a_only", {62'd0, xa, xb}, 64'd2);
`endif
            if (xa) na++;
            if (xb) nb++;
        end
        drive(1'b0, '0, 1'b1, DATA_W'(16'h500 + nb), 1'b0, 1'b0, xa, xb);
        check_eq("b_after_a_drops", {63'd0, xb}, 64'd1);
        drain();

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

endmodule
`default_nettype wire
